oam_dma: RTL and testbench

OAM DMA controller for the $4014 register. On a CPU write to $4014 it halts the CPU, then sequences 256 read/write pairs that copy one 256-byte CPU page into sprite memory through the $2004 (OAMDATA) register. It sits between the CPU bus decoder and the shared memory/PPU-register request bus, acting as a second bus master while the CPU is halted.

---
 rtl/oam_dma.sv | 95 +++++++++
 tb/tb_oam_dma.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to $4014 halts the CPU and copies one 256-byte page
// into sprite memory through OAMDATA, one read/write pair per two CPU cycles.
//
// state  | meaning
// IDLE   | waiting for a $4014 write
// HALT   | CPU is finishing its write cycle
// ALIGN  | one extra tick so reads start on an even phase
// RDREQ  | read request {page,cnt} outstanding
// RDWAIT | read done, wait for the next CPU cycle
// WRREQ  | write of the buffered byte to OAMDATA outstanding
// WRWAIT | write done, wait for the next CPU cycle
// DONE   | last byte written, release the CPU on the next tick
module oam_dma #(
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        wr4014,
  input  logic [7:0]  wdata4014,
  output logic        halt,
  output logic        busy,
  output logic        dmareq,
  output logic        dmawr,
  output logic [15:0] dmaaddr,
  output logic [7:0]  dmawdata,
  input  logic        dmaack,
  input  logic [7:0]  dmardata
);

  typedef enum logic [2:0] {
    IDLE, HALT, ALIGN, RDREQ, RDWAIT, WRREQ, WRWAIT, DONE
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] page;
  logic [7:0] cnt;
  logic [7:0] data_buf;
  logic       phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      page     <= 8'h00;
      cnt      <= 8'h00;
      data_buf <= 8'h00;
      phase    <= 1'b0;
      halt     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (tick) phase <= ~phase;
      if (state == IDLE && wr4014) begin
        page <= wdata4014;
        cnt  <= 8'h00;
        halt <= 1'b1;
      end
      if (state == RDREQ && dmaack) data_buf <= dmardata;
      // terminal byte is detected before the increment, so cnt never wraps mid-transfer
      if (state == WRWAIT && tick && cnt != 8'hFF) cnt <= cnt + 8'd1;
      if (state == DONE && tick) halt <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    dmareq    = 1'b0;
    dmawr     = 1'b0;
    dmaaddr   = 16'h0000;
    dmawdata  = 8'h00;
    case (state)
      IDLE:   if (wr4014) state_nxt = HALT;
      // phase is about to toggle: current 1 means the post-toggle phase is even
      HALT:   if (tick) state_nxt = phase ? RDREQ : ALIGN;
      ALIGN:  if (tick) state_nxt = RDREQ;
      RDREQ: begin
        dmareq  = 1'b1;
        dmaaddr = {page, cnt};
        if (dmaack) state_nxt = RDWAIT;
      end
      RDWAIT: if (tick) state_nxt = WRREQ;
      WRREQ: begin
        dmareq   = 1'b1;
        dmawr    = 1'b1;
        dmaaddr  = OAMDATA_ADDR;
        dmawdata = data_buf;
        if (dmaack) state_nxt = WRWAIT;
      end
      WRWAIT: if (tick) state_nxt = (cnt == 8'hFF) ? DONE : RDREQ;
      DONE:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: random tick spacing and memory contents, a bus
// responder that logs every request, and per-scenario checks against the expected copy.
module tb_oam_dma;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        wr4014 = 1'b0;
  logic [7:0]  wdata4014 = 8'h00;
  logic        halt, busy, dmareq, dmawr;
  logic [15:0] dmaaddr;
  logic [7:0]  dmawdata;
  logic        dmaack = 1'b0;
  logic [7:0]  dmardata = 8'h00;

  int checks = 0;
  int errors = 0;

  oam_dma #(.OAMDATA_ADDR(16'h2004)) dut (
    .clk(clk), .reset(reset), .tick(tick), .wr4014(wr4014), .wdata4014(wdata4014),
    .halt(halt), .busy(busy), .dmareq(dmareq), .dmawr(dmawr), .dmaaddr(dmaaddr),
    .dmawdata(dmawdata), .dmaack(dmaack), .dmardata(dmardata)
  );

  always #5 clk = ~clk;

  // observed bus requests and the expected transfer
  logic        log_wr[$];
  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];
  logic        exp_wr[$];
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_data[$];

  logic [7:0]  mem_key = 8'h5A;
  logic        tick_en = 1'b1;
  logic        spurious_en = 1'b0;
  int          delay_idx = -1;
  int          delay_ticks = 0;

  logic        phase_m = 1'b0;
  int          tick_total = 0, halt_ticks = 0, halt_rises = 0, halt_falls = 0, hold_bad = 0;
  logic        trig_phase = 1'b0, first_rd_phase = 1'b0;
  int          last_ack_tick = 0, fall_tick = 0;

  int          gap = 2, t0 = 0, this_delay = 0;
  logic        req_seen = 1'b0, acked = 1'b0, prev_tick = 1'b0, prev_reset = 1'b1, halt_prev = 1'b0;
  logic        cur_wr = 1'b0;
  logic [15:0] cur_addr = 16'h0000;
  logic [7:0]  cur_wdata = 8'h00;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ mem_key;
  endfunction

  // a transfer is byte k read from {page,k} then written to OAMDATA, k = 0..255
  function automatic void build_expected(input logic [7:0] page);
    exp_wr.delete(); exp_addr.delete(); exp_data.delete();
    for (int k = 0; k < 256; k++) begin
      exp_wr.push_back(1'b0); exp_addr.push_back({page, 8'(k)}); exp_data.push_back(mem_byte({page, 8'(k)}));
      exp_wr.push_back(1'b1); exp_addr.push_back(16'h2004);      exp_data.push_back(mem_byte({page, 8'(k)}));
    end
  endfunction

  // Runs at every negedge: accounts for the edge just taken, answers the bus, picks the next tick.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_tick && halt_prev) begin
        if (halt_ticks == 0) trig_phase = phase_m;
        halt_ticks++;
      end
      if (prev_tick) tick_total++;
      if (prev_reset) phase_m = 1'b0;
      else if (prev_tick) phase_m = ~phase_m;
      if (halt && !halt_prev) halt_rises++;
      if (!halt && halt_prev) begin halt_falls++; fall_tick = tick_total; end
      halt_prev = halt;

      dmaack = 1'b0;
      dmardata = 8'($urandom);
      if (!dmareq) begin
        req_seen = 1'b0;
        if (spurious_en && $urandom_range(0, 3) == 0) dmaack = 1'b1;
      end else begin
        if (!req_seen || acked) begin
          req_seen = 1'b1; acked = 1'b0;
          cur_wr = dmawr; cur_addr = dmaaddr; cur_wdata = dmawdata;
          t0 = tick_total;
          if (log_addr.size() == 0) first_rd_phase = phase_m;
          this_delay = (log_addr.size() == delay_idx) ? delay_ticks : 0;
          log_wr.push_back(dmawr); log_addr.push_back(dmaaddr); log_data.push_back(dmawdata);
        end else if (dmawr !== cur_wr || dmaaddr !== cur_addr || (cur_wr && dmawdata !== cur_wdata)) begin
          hold_bad++;
        end
        if (tick_total - t0 >= this_delay) begin
          dmaack = 1'b1; acked = 1'b1; last_ack_tick = tick_total;
          if (!cur_wr) dmardata = mem_byte(cur_addr);
        end
      end

      if (tick_en && gap == 0) begin
        tick = 1'b1; gap = $urandom_range(1, 4);
      end else begin
        tick = 1'b0;
        if (tick_en && gap > 0) gap--;
      end
      prev_tick = tick; prev_reset = reset;
    end
  end

  task automatic start_transfer(input logic [7:0] page);
    log_wr.delete(); log_addr.delete(); log_data.delete();
    halt_ticks = 0; halt_rises = 0; halt_falls = 0; hold_bad = 0;
    build_expected(page);
    @(posedge clk); #1;
    wr4014 = 1'b1; wdata4014 = page;
    @(posedge clk); #1;
    wr4014 = 1'b0; wdata4014 = 8'($urandom);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (halt_falls > 0) begin ok = 1'b1; break; end
    end
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (halt !== 1'b0)       begin errors++; $display("FAIL reset_halt got %b want 0", halt); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (dmareq !== 1'b0)     begin errors++; $display("FAIL reset_dmareq got %b want 0", dmareq); end
    checks++; if (dmawr !== 1'b0)      begin errors++; $display("FAIL reset_dmawr got %b want 0", dmawr); end
    checks++; if (dmaaddr !== 16'h0)   begin errors++; $display("FAIL reset_dmaaddr got %h want 0000", dmaaddr); end
    checks++; if (dmawdata !== 8'h0)   begin errors++; $display("FAIL reset_dmawdata got %h want 00", dmawdata); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    bit ok;
    int want_len;
    mem_key = 8'h5A;
    start_transfer(8'h02);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got busy want done"); end
    checks++; if (log_addr.size() != 512) begin errors++; $display("FAIL basic_len got %0d want 512", log_addr.size()); end
    for (int i = 0; i < 512 && i < log_addr.size(); i++) begin
      checks++;
      if (log_wr[i] !== exp_wr[i] || log_addr[i] !== exp_addr[i] || (exp_wr[i] && log_data[i] !== exp_data[i])) begin
        errors++;
        $display("FAIL basic_seq[%0d] got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                 i, log_wr[i], log_addr[i], log_data[i], exp_wr[i], exp_addr[i], exp_data[i]);
        break;
      end
    end
    // the first halted tick retires the CPU write; length counts the ticks after it
    want_len = (trig_phase == 1'b0) ? 514 : 513;
    checks++; if (halt_ticks - 1 != want_len) begin errors++; $display("FAIL basic_halt_len got %0d want %0d", halt_ticks - 1, want_len); end
    checks++; if (first_rd_phase !== 1'b0) begin errors++; $display("FAIL basic_first_phase got %b want 0", first_rd_phase); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL basic_hold got %0d want 0", hold_bad); end
    checks++; if (busy !== 1'b0 || halt !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b halt=%b want 0 0", busy, halt); end
  endtask

  task automatic test_phase;
    bit ok;
    logic [7:0] page;
    for (int want = 0; want < 2; want++) begin
      mem_key = 8'($urandom);
      page = 8'($urandom);
      tick_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      if (phase_m != want[0]) begin
        tick_en = 1'b1;
        for (int i = 0; i < 50 && phase_m != want[0]; i++) begin @(posedge clk); #1; end
        tick_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      start_transfer(page);
      tick_en = 1'b1;
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL phase%0d_timeout got busy want done", want); end
      checks++; if (log_addr.size() != 512) begin errors++; $display("FAIL phase%0d_len got %0d want 512", want, log_addr.size()); end
      for (int i = 0; i < 512 && i < log_addr.size(); i++) begin
        checks++;
        if (log_wr[i] !== exp_wr[i] || log_addr[i] !== exp_addr[i] || (exp_wr[i] && log_data[i] !== exp_data[i])) begin
          errors++;
          $display("FAIL phase%0d_seq[%0d] got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                   want, i, log_wr[i], log_addr[i], log_data[i], exp_wr[i], exp_addr[i], exp_data[i]);
          break;
        end
      end
      checks++;
      if (halt_ticks - 1 != (want == 0 ? 514 : 513)) begin
        errors++; $display("FAIL phase%0d_halt_len got %0d want %0d", want, halt_ticks - 1, want == 0 ? 514 : 513);
      end
      checks++; if (first_rd_phase !== 1'b0) begin errors++; $display("FAIL phase%0d_first_phase got %b want 0", want, first_rd_phase); end
    end
  endtask

  task automatic test_delayed_ack;
    bit ok;
    mem_key = 8'($urandom);
    delay_idx = 72;
    delay_ticks = 5;
    start_transfer(8'h02);
    wait_done(ok);
    delay_idx = -1;
    checks++; if (!ok) begin errors++; $display("FAIL delay_timeout got busy want done"); end
    checks++; if (log_addr.size() != 512) begin errors++; $display("FAIL delay_len got %0d want 512", log_addr.size()); end
    for (int i = 0; i < 512 && i < log_addr.size(); i++) begin
      checks++;
      if (log_wr[i] !== exp_wr[i] || log_addr[i] !== exp_addr[i] || (exp_wr[i] && log_data[i] !== exp_data[i])) begin
        errors++;
        $display("FAIL delay_seq[%0d] got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                 i, log_wr[i], log_addr[i], log_data[i], exp_wr[i], exp_addr[i], exp_data[i]);
        break;
      end
    end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL delay_hold got %0d want 0", hold_bad); end
  endtask

  task automatic test_ignore_rewrite;
    bit ok;
    mem_key = 8'($urandom);
    spurious_en = 1'b1;
    start_transfer(8'h03);
    for (int i = 0; i < 20000 && log_addr.size() < 129; i++) begin @(posedge clk); #1; end
    wr4014 = 1'b1; wdata4014 = 8'h07;
    @(posedge clk); #1;
    wr4014 = 1'b0;
    wait_done(ok);
    spurious_en = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL rewrite_timeout got busy want done"); end
    checks++; if (log_addr.size() != 512) begin errors++; $display("FAIL rewrite_len got %0d want 512", log_addr.size()); end
    for (int i = 0; i < 512 && i < log_addr.size(); i++) begin
      checks++;
      if (log_wr[i] !== exp_wr[i] || log_addr[i] !== exp_addr[i] || (exp_wr[i] && log_data[i] !== exp_data[i])) begin
        errors++;
        $display("FAIL rewrite_seq[%0d] got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                 i, log_wr[i], log_addr[i], log_data[i], exp_wr[i], exp_addr[i], exp_data[i]);
        break;
      end
    end
    checks++; if (halt_rises != 1 || halt_falls != 1) begin errors++; $display("FAIL rewrite_halt_edges got rise=%0d fall=%0d want 1 1", halt_rises, halt_falls); end
    checks++; if (halt !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rewrite_idle got halt=%b busy=%b want 0 0", halt, busy); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    mem_key = 8'($urandom);
    delay_idx = 257;
    delay_ticks = 1000000;
    start_transfer(8'($urandom));
    for (int i = 0; i < 20000 && log_addr.size() < 258; i++) begin @(posedge clk); #1; end
    checks++;
    if (dmareq !== 1'b1 || dmawr !== 1'b1 || dmaaddr !== 16'h2004) begin
      errors++; $display("FAIL rstmid_wrreq got req=%b wr=%b addr=%h want 1 1 2004", dmareq, dmawr, dmaaddr);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (halt !== 1'b0)   begin errors++; $display("FAIL rstmid_halt got %b want 0", halt); end
    checks++; if (dmareq !== 1'b0) begin errors++; $display("FAIL rstmid_dmareq got %b want 0", dmareq); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    reset = 1'b0;
    delay_idx = -1;
    repeat (3) @(posedge clk);
    #1;
    start_transfer(8'h05);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got busy want done"); end
    checks++;
    if (log_addr.size() == 0 || log_addr[0] !== 16'h0500) begin
      errors++; $display("FAIL rstmid_first_addr got %h want 0500", log_addr.size() == 0 ? 16'hxxxx : log_addr[0]);
    end
    checks++; if (log_addr.size() != 512) begin errors++; $display("FAIL rstmid_len got %0d want 512", log_addr.size()); end
    for (int i = 0; i < 512 && i < log_addr.size(); i++) begin
      checks++;
      if (log_wr[i] !== exp_wr[i] || log_addr[i] !== exp_addr[i] || (exp_wr[i] && log_data[i] !== exp_data[i])) begin
        errors++;
        $display("FAIL rstmid_seq[%0d] got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                 i, log_wr[i], log_addr[i], log_data[i], exp_wr[i], exp_addr[i], exp_data[i]);
        break;
      end
    end
  endtask

  task automatic test_last_byte;
    bit ok;
    mem_key = 8'($urandom);
    start_transfer(8'hFF);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL last_timeout got busy want done"); end
    checks++; if (log_addr.size() != 512) begin errors++; $display("FAIL last_len got %0d want 512", log_addr.size()); end
    for (int i = 0; i < 512 && i < log_addr.size(); i++) begin
      checks++;
      if (log_wr[i] !== exp_wr[i] || log_addr[i] !== exp_addr[i] || (exp_wr[i] && log_data[i] !== exp_data[i])) begin
        errors++;
        $display("FAIL last_seq[%0d] got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                 i, log_wr[i], log_addr[i], log_data[i], exp_wr[i], exp_addr[i], exp_data[i]);
        break;
      end
    end
    // one tick closes the final write cycle, the next one (in DONE) drops halt
    checks++; if (fall_tick - last_ack_tick != 2) begin errors++; $display("FAIL last_halt_drop got %0d ticks want 2", fall_tick - last_ack_tick); end
    checks++; if (halt_falls != 1 || busy !== 1'b0) begin errors++; $display("FAIL last_idle got falls=%0d busy=%b want 1 0", halt_falls, busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_phase();
    test_delayed_ack();
    test_ignore_rewrite();
    test_reset_mid();
    test_last_byte();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
